// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 8:1 mux arbiter.
// FSM state encodings, requester count, and the rotate-priority pick function.
// Used by the interface, the mux sub-module, and the arbiter top.
package mux8_rr_arbiter_pkg;

  localparam int NREQ = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  // Return the first set request bit found by searching ptr, ptr+1, ... ptr+7 (mod 8).
  // The result is only meaningful when req is nonzero.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    // Walk from the farthest slot back toward ptr so the nearest set bit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Bundle of the requester side and the sink side of the arbiter.
// master: the arbiter itself. slave: the sources plus the downstream sink.
// The sink stalls the arbiter by holding o_ready low.
interface mux8_rr_arbiter_if #(parameter int WIDTH = 32);
  import mux8_rr_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
  logic [NREQ-1:0] ack;
  logic [2:0]       s;
  logic             busy;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_src;

  modport master (
    input  req, last, I0, I1, I2, I3, I4, I5, I6, I7, o_ready,
    output ack, s, busy, o_valid, o_data, o_src
  );

  modport slave (
    output req, last, I0, I1, I2, I3, I4, I5, I6, I7, o_ready,
    input  ack, s, busy, o_valid, o_data, o_src
  );
endinterface

// File: rtl/mux8_rr_arbiter_mux.sv
// Plain 8:1 word mux (the MUX8T1_32 data path) driven by the registered select.
// Purely combinational, zero latency.
// No flow control of its own.
module mux8_rr_arbiter_mux #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7,
  output logic [WIDTH-1:0] o
);

  // Select one of the eight source words.
  always_comb begin
    o = I0;
    case (s)
      3'd0: o = I0;
      3'd1: o = I1;
      3'd2: o = I2;
      3'd3: o = I3;
      3'd4: o = I4;
      3'd5: o = I5;
      3'd6: o = I6;
      3'd7: o = I7;
      default: o = I0;
    endcase
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among eight burst requesters.
// Grant one cycle after a request in IDLE; beats then pass combinationally, one per cycle.
// Sink stall (o_ready=0) freezes the grant; an idle granted requester is dropped after TIMEOUT cycles.
module mux8_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic              clk,
  input logic              rst,
  mux8_rr_arbiter_if.master bus
);
  import mux8_rr_arbiter_pkg::*;

  logic            state;
  logic [2:0]      s_q;
  logic [2:0]      ptr;
  logic [TO_W-1:0] to_cnt;

  logic            req_s;
  logic            last_s;
  logic            valid;
  logic            accept;
  logic [NREQ-1:0] ack_vec;

  // Handshake for the currently granted requester.
  always_comb begin
    req_s   = bus.req[s_q];
    last_s  = bus.last[s_q];
    valid   = (state == ST_BUSY) && req_s;
    accept  = valid && bus.o_ready;
    ack_vec = '0;
    if (accept) ack_vec[s_q] = 1'b1;
  end

  // Grant FSM: arbitrate in IDLE, hold the grant in BUSY until last beat or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      s_q    <= 3'd0;
      ptr    <= 3'd0;
      to_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            s_q    <= rr_pick(bus.req, ptr);
            state  <= ST_BUSY;
            to_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (accept && last_s) begin
            state  <= ST_IDLE;
            ptr    <= s_q + 3'd1;
            to_cnt <= '0;
          end else if (req_s) begin
            to_cnt <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state  <= ST_IDLE;
            ptr    <= s_q + 3'd1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mux8_rr_arbiter_mux #(.WIDTH(WIDTH)) u_mux (
    .s  (s_q),
    .I0 (bus.I0), .I1 (bus.I1), .I2 (bus.I2), .I3 (bus.I3),
    .I4 (bus.I4), .I5 (bus.I5), .I6 (bus.I6), .I7 (bus.I7),
    .o  (bus.o_data)
  );

  // Registered select doubles as the source tag; busy mirrors the FSM state.
  assign bus.s       = s_q;
  assign bus.o_src   = s_q;
  assign bus.busy    = (state == ST_BUSY);
  assign bus.o_valid = valid;
  assign bus.ack     = ack_vec;

endmodule
